ram_frontend_clr: RTL

- Parametrised RAM front-end between the machine core and one single-port RAM.
- Takes over the job of the top-level registered RAM staging and the power-on RAM fill, and also accepts tape-loader writes.
- Adds a software-triggerable clear, a selectable fill pattern, and a one-entry buffered loader write port. Loader writes share the RAM port with the CPU at lower priority, so the separate dual-port loader path is no longer needed.

---
 rtl/ram_frontend_clr.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ram_frontend_clr.sv
// RAM front-end: registered staging of core accesses to one single-port RAM,
// a power-on / software-triggered fill sweep, and a one-entry buffered loader
// write port that borrows idle RAM cycles from the core.
module ram_frontend_clr #(
   parameter int unsigned   AW          = 16,
   parameter int unsigned   DW          = 8,
   parameter int unsigned   FILL_MODE   = 0,
   parameter logic [DW-1:0] FILL_VAL    = {DW{1'b1}},
   parameter int unsigned   STRIPE_LOG2 = 7
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done,
   input  logic [AW-1:0] cpu_a,
   input  logic [DW-1:0] cpu_d,
   input  logic          cpu_cs,
   input  logic          cpu_we,
   input  logic [AW-1:0] ldr_a,
   input  logic [DW-1:0] ldr_d,
   input  logic          ldr_we,
   output logic          ldr_wait,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_d,
   output logic          mem_cs,
   output logic          mem_we
);

   typedef enum logic [0:0] {StClear, StRun} state_e;

   state_e        state_q, state_d;
   // One extra bit: cnt_q[AW] set means every address has been written and
   // the next edge finishes the sweep.
   logic [AW:0]   cnt_q, cnt_d;
   logic          buf_valid_q, buf_valid_d;
   logic [AW-1:0] buf_a_q, buf_a_d;
   logic [DW-1:0] buf_d_q, buf_d_d;
   logic [AW-1:0] mem_a_q, mem_a_d;
   logic [DW-1:0] mem_d_q, mem_d_d;
   logic          mem_cs_q, mem_cs_d;
   logic          mem_we_q, mem_we_d;
   logic          clr_busy_q, clr_busy_d;
   logic          clr_done_q, clr_done_d;
   logic          ldr_wait_q, ldr_wait_d;

   // Fill word depends only on the stripe-select address bit.
   function automatic logic [DW-1:0] fill_word(input logic stripe_bit);
      if ((FILL_MODE == 1) && stripe_bit) begin
         return ~FILL_VAL;
      end
      return FILL_VAL;
   endfunction

   // Next-state: sweep sequencing, core/loader arbitration and loader buffer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      buf_valid_d = buf_valid_q;
      buf_a_d     = buf_a_q;
      buf_d_d     = buf_d_q;
      mem_a_d     = mem_a_q;
      mem_d_d     = mem_d_q;
      mem_cs_d    = 1'b0;
      mem_we_d    = 1'b0;
      clr_busy_d  = clr_busy_q;
      clr_done_d  = 1'b0;

      unique case (state_q)
         StClear: begin
            // Core, loader and clr_req are all ignored while sweeping.
            buf_valid_d = 1'b0;
            if (!cnt_q[AW]) begin
               mem_a_d  = cnt_q[AW-1:0];
               mem_d_d  = fill_word(cnt_q[STRIPE_LOG2]);
               mem_cs_d = 1'b1;
               mem_we_d = 1'b1;
               cnt_d    = cnt_q + (AW+1)'(1);
            end else begin
               cnt_d      = '0;
               clr_busy_d = 1'b0;
               clr_done_d = 1'b1;
               state_d    = StRun;
            end
         end
         StRun: begin
            clr_busy_d = 1'b0;
            if (clr_req) begin
               // Sweep wins: any core access this cycle and any buffered
               // loader write are dropped.
               state_d     = StClear;
               cnt_d       = '0;
               clr_busy_d  = 1'b1;
               buf_valid_d = 1'b0;
            end else begin
               if (cpu_cs) begin
                  mem_a_d  = cpu_a;
                  mem_d_d  = cpu_d;
                  mem_cs_d = 1'b1;
                  mem_we_d = cpu_we;
               end else if (buf_valid_q) begin
                  mem_a_d     = buf_a_q;
                  mem_d_d     = buf_d_q;
                  mem_cs_d    = 1'b1;
                  mem_we_d    = 1'b1;
                  buf_valid_d = 1'b0;
               end
               // ldr_wait_q low implies the buffer is empty, so capture and
               // drain never coincide.
               if (ldr_we && !ldr_wait_q) begin
                  buf_valid_d = 1'b1;
                  buf_a_d     = ldr_a;
                  buf_d_d     = ldr_d;
               end
            end
         end
         default: begin
            state_d = StClear;
            cnt_d   = '0;
         end
      endcase

      ldr_wait_d = (state_d == StClear) | buf_valid_d;
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StClear;
         cnt_q       <= '0;
         buf_valid_q <= 1'b0;
         buf_a_q     <= '0;
         buf_d_q     <= '0;
         mem_a_q     <= '0;
         mem_d_q     <= '0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         clr_busy_q  <= 1'b1;
         clr_done_q  <= 1'b0;
         ldr_wait_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_valid_q <= buf_valid_d;
         buf_a_q     <= buf_a_d;
         buf_d_q     <= buf_d_d;
         mem_a_q     <= mem_a_d;
         mem_d_q     <= mem_d_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         clr_busy_q  <= clr_busy_d;
         clr_done_q  <= clr_done_d;
         ldr_wait_q  <= ldr_wait_d;
      end
   end

   assign mem_a    = mem_a_q;
   assign mem_d    = mem_d_q;
   assign mem_cs   = mem_cs_q;
   assign mem_we   = mem_we_q;
   assign clr_busy = clr_busy_q;
   assign clr_done = clr_done_q;
   assign ldr_wait = ldr_wait_q;

endmodule
